// File: rtl/line_write_buffer.sv
// rtl/line_write_buffer.sv - write buffer for evicted dirty cache lines
// Circular FIFO drained one line at a time to memory; coalesces and serves lookups.
module line_write_buffer #(
  parameter int LINE_BITS = 128,
  parameter int ADDR_BITS = 16,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [ADDR_BITS-1:0]   enq_addr,
  input  logic [LINE_BITS-1:0]   enq_data,
  input  logic [ADDR_BITS-1:0]   lookup_addr,
  output logic                   lookup_hit,
  output logic [LINE_BITS-1:0]   lookup_data,
  output logic [ADDR_BITS-1:0]   pmem_address,
  output logic [LINE_BITS-1:0]   pmem_wdata,
  output logic                   pmem_write,
  input  logic                   pmem_resp,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t               state_q, state_d;
  logic                 valid_q [DEPTH];
  logic                 valid_d [DEPTH];
  logic [ADDR_BITS-1:0] addr_q  [DEPTH];
  logic [ADDR_BITS-1:0] addr_d  [DEPTH];
  logic [LINE_BITS-1:0] data_q  [DEPTH];
  logic [LINE_BITS-1:0] data_d  [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 pmem_write_q, pmem_write_d;
  logic [ADDR_BITS-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_BITS-1:0] pmem_wdata_q, pmem_wdata_d;

  logic                 coal_hit;
  logic [PTR_W-1:0]     coal_idx;
  logic                 append;
  logic                 pop;

  // Walk from head to tail so the last match seen is the youngest entry.
  // The head is excluded from coalescing while its write is in flight.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    coal_hit    = 1'b0;
    coal_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[head_q + PTR_W'(k)] && addr_q[head_q + PTR_W'(k)] == lookup_addr) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[head_q + PTR_W'(k)];
      end
      if (valid_q[head_q + PTR_W'(k)] && addr_q[head_q + PTR_W'(k)] == enq_addr &&
          !(state_q == WRITE && k == 0)) begin
        coal_hit = 1'b1;
        coal_idx = head_q + PTR_W'(k);
      end
    end
  end

  assign enq_ready = (count_q < FULL) || coal_hit;
  assign append    = enq_valid && enq_ready && !coal_hit;
  assign pop       = (state_q == WRITE) && pmem_resp;

  always_comb begin
    valid_d        = valid_q;
    addr_d         = addr_q;
    data_d         = data_q;
    head_d         = head_q;
    tail_d         = tail_q;
    state_d        = state_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;

    if (enq_valid && coal_hit) begin
      data_d[coal_idx] = enq_data;
    end else if (append) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = enq_addr;
      data_d[tail_q]  = enq_data;
      tail_d          = tail_q + 1'b1;
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    count_d = count_q + CNT_W'(append) - CNT_W'(pop);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d        = WRITE;
          pmem_write_d   = 1'b1;
          pmem_address_d = addr_q[head_q];
          // A same-cycle coalesce into the head must reach memory, not be lost.
          pmem_wdata_d   = (enq_valid && coal_hit && coal_idx == head_q) ? enq_data
                                                                         : data_q[head_q];
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          pmem_write_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      valid_q        <= valid_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
    end
  end

  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);

endmodule

// File: tb/tb_line_write_buffer.sv
// tb/tb_line_write_buffer.sv - bench for line_write_buffer
// Queue-based reference model; directed scenarios followed by random traffic.
module tb_line_write_buffer;

  localparam int DEPTH = 4;

  logic         clk;
  logic         reset;
  logic         enq_valid;
  logic         enq_ready;
  logic [15:0]  enq_addr;
  logic [127:0] enq_data;
  logic [15:0]  lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_write;
  logic         pmem_resp;
  logic         empty;
  logic [2:0]   count;

  line_write_buffer #(.LINE_BITS(128), .ADDR_BITS(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr), .enq_data(enq_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: queue index 0 is the oldest line; m_writing marks a line in flight.
  logic [15:0]  m_addr [$];
  logic [127:0] m_data [$];
  bit           m_writing;
  logic [15:0]  m_wr_addr;
  logic [127:0] m_wr_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step(input bit ev, input logic [15:0] ea, input logic [127:0] ed,
                      input logic [15:0] la, input bit resp, input bit rst);
    int ci;
    int n;
    bit m_hit;
    bit m_ready;
    logic [127:0] m_ld;
    @(negedge clk);
    reset = rst; enq_valid = ev; enq_addr = ea; enq_data = ed;
    lookup_addr = la; pmem_resp = resp;
    #1;
    n = m_addr.size();
    ci = -1; m_hit = 0; m_ld = '0;
    for (int i = 0; i < n; i++) begin
      if (m_addr[i] == ea && !(m_writing && i == 0)) ci = i;
      if (m_addr[i] == la) begin m_hit = 1; m_ld = m_data[i]; end
    end
    m_ready = (n < DEPTH) || (ci >= 0);
    check("enq_ready", 128'(enq_ready), 128'(m_ready));
    check("lookup_hit", 128'(lookup_hit), 128'(m_hit));
    check("lookup_data", lookup_data, m_ld);
    check("pmem_write", 128'(pmem_write), 128'(m_writing));
    if (m_writing) begin
      check("pmem_address", 128'(pmem_address), 128'(m_wr_addr));
      check("pmem_wdata", pmem_wdata, m_wr_data);
    end
    check("count", 128'(count), 128'(n));
    check("empty", 128'(empty), 128'(n == 0));
    if (rst) begin
      m_addr.delete(); m_data.delete(); m_writing = 0;
    end else begin
      if (ev && m_ready) begin
        if (ci >= 0) m_data[ci] = ed;
        else begin m_addr.push_back(ea); m_data.push_back(ed); end
      end
      if (m_writing) begin
        if (resp) begin
          void'(m_addr.pop_front()); void'(m_data.pop_front());
          m_writing = 0;
        end
      end else if (n > 0) begin
        m_writing = 1; m_wr_addr = m_addr[0]; m_wr_data = m_data[0];
      end
    end
  endtask

  task automatic idle(input bit resp);
    step(0, 16'h0, '0, 16'h0, resp, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (m_addr.size() > 0 || m_writing); i++) idle(1);
    idle(0);
    check("drained", 128'(count), 128'(0));
  endtask

  logic [127:0] d1, da, db;

  initial begin
    clk = 0; reset = 1; enq_valid = 0; enq_addr = '0; enq_data = '0;
    lookup_addr = '0; pmem_resp = 0;
    m_writing = 0; m_wr_addr = '0; m_wr_data = '0;

    step(0, 16'h0, '0, 16'h0, 0, 1);
    idle(0);
    check("rst_addr", 128'(pmem_address), 128'(0));
    check("rst_wdata", pmem_wdata, 128'(0));
    check("rst_empty", 128'(empty), 128'(1));

    // single write held for three cycles
    d1 = rnd_line();
    step(1, 16'h0120, d1, 16'h0120, 0, 0);
    idle(0);
    for (int i = 0; i < 3; i++) begin
      idle(i == 2);
      check("d1_addr", 128'(pmem_address), 128'(16'h0120));
      check("d1_wdata", pmem_wdata, d1);
    end
    idle(0);
    check("d1_count", 128'(count), 128'(0));
    check("d1_empty", 128'(empty), 128'(1));

    // full buffer: new address refused, existing address coalesced
    for (int i = 1; i <= 4; i++) step(1, 16'(i * 16), rnd_line(), 16'h0, 0, 0);
    step(1, 16'h0050, rnd_line(), 16'h0, 0, 0);
    check("full_new_ready", 128'(enq_ready), 128'(0));
    da = rnd_line();
    step(1, 16'h0030, da, 16'h0, 0, 0);
    check("full_coal_ready", 128'(enq_ready), 128'(1));
    step(0, 16'h0, '0, 16'h0030, 0, 0);
    check("coal_data", lookup_data, da);
    check("coal_count", 128'(count), 128'(4));
    drain();

    // enqueue the in-flight head address again
    da = rnd_line(); db = rnd_line();
    step(1, 16'h0010, da, 16'h0, 0, 0);
    idle(0);
    step(1, 16'h0010, db, 16'h0, 0, 0);
    step(0, 16'h0, '0, 16'h0010, 0, 0);
    check("head_dup_count", 128'(count), 128'(2));
    check("head_dup_lookup", lookup_data, db);
    check("head_dup_wdata", pmem_wdata, da);
    drain();

    // full buffer, enqueue collides with pop
    for (int i = 1; i <= 4; i++) step(1, 16'(i * 16), rnd_line(), 16'h0, 0, 0);
    step(1, 16'h0099, rnd_line(), 16'h0, 1, 0);
    check("pop_same_cycle_ready", 128'(enq_ready), 128'(0));
    step(1, 16'h0099, rnd_line(), 16'h0, 0, 0);
    check("pop_next_ready", 128'(enq_ready), 128'(1));
    idle(0);
    check("pop_refill_count", 128'(count), 128'(DEPTH));
    drain();

    // reset in the middle of a write
    for (int i = 1; i <= 3; i++) step(1, 16'(16'h0200 + i), rnd_line(), 16'h0, 0, 0);
    idle(0);
    step(0, 16'h0, '0, 16'h0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      step(0, 16'h0, '0, 16'(16'h0200 + i), 1, 0);
      check("rst_mid_hit", 128'(lookup_hit), 128'(0));
    end
    check("rst_mid_write", 128'(pmem_write), 128'(0));

    // pointer wrap: 2*DEPTH+1 enqueue/drain pairs
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      step(1, 16'(16'h0400 + k), rnd_line(), 16'h0, 0, 0);
      drain();
    end

    // random traffic over a small address pool to force coalescing
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 1) == 1, 16'(16'h0100 + 16 * $urandom_range(0, 7)), rnd_line(),
           16'(16'h0100 + 16 * $urandom_range(0, 7)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 299) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
